ebu_arb: RTL
============

EBU_ARB -- requirements
Module: ebu_arb

Interface
REQ-001 Parameter BEATW, 3, width of burst-length and beat-count fields; max burst = 2^BEATW beats.
REQ-002 Parameter FAIRLIMIT, 2, consecutive contested LSU wins before the IFU is forced to win.
REQ-003 HCLK  in  1  bus and core clock, rising-edge.
REQ-004 HRESETn  in  1  reset, asynchronous assert, active-low.
REQ-005 IFUReq / LSUReq  in  1 each  requester wants the bus.
REQ-006 IFUBurstLen / LSUBurstLen  in  BEATW each  beats minus 1 for the pending request.
REQ-007 IFUHTRANS / LSUHTRANS  in  2 each  requester's AHB transfer type (00 IDLE, 10 NONSEQ, 11 SEQ).
REQ-008 HREADY  in  1  AHB subordinate ready.
REQ-009 IFUGnt / LSUGnt  out  1 each  requester owns the bus (one-hot or zero).
REQ-010 LSUSel  out  1  address/control mux select: 1 LSU, 0 IFU.
REQ-011 HTRANS  out  2  muxed transfer type to AHB.
REQ-012 IFUStall / LSUStall  out  1 each  request pending but not granted.
REQ-013 BeatCnt  out  BEATW  address beats accepted in current tenure.
REQ-014 BusBusy  out  1  state != IDLE.

Function
REQ-015 States SHALL be IDLE, ADDR, LASTDATA; all state registers update on the rising HCLK edge.
REQ-016 IDLE: grants 0; if IFUReq or LSUReq, SHALL register the winner into LSUSel, latch the winner's BurstLen into Len, clear BeatCnt, and go to ADDR (grant visible 1 cycle after request).
REQ-017 Winner: LSU if LSUReq alone; IFU if IFUReq alone; if both, LSU unless StarveCnt == FAIRLIMIT, in which case IFU.
REQ-018 StarveCnt (2 bits, saturating) SHALL increment when LSU wins while IFUReq is high and SHALL clear when IFU wins; otherwise it holds.
REQ-019 ADDR: grant of the selected requester = 1, the other = 0; HTRANS = selected requester's HTRANS.
REQ-020 Beat accepted when ADDR & HREADY & HTRANS[1]; if BeatCnt == Len go to LASTDATA, else BeatCnt increments by 1.
REQ-021 Abort: in ADDR with BeatCnt == 0, owner request low and owner HTRANS == IDLE, SHALL return to IDLE next cycle without accepting a beat.
REQ-022 LASTDATA: grant held, HTRANS = 00; on HREADY go to IDLE; otherwise remain.
REQ-023 HTRANS SHALL be 00 in IDLE and LASTDATA regardless of requester inputs.
REQ-024 Requester inputs changing during ADDR/LASTDATA SHALL NOT change LSUSel, Len or ownership (no preemption).
REQ-025 IFUStall = IFUReq & ~IFUGnt | IFUGnt & state != IDLE & ~(LASTDATA & HREADY); LSUStall symmetric.
REQ-026 Back-to-back: a request pending when LASTDATA exits SHALL be arbitrated in the following IDLE cycle (one idle cycle between tenures).
REQ-027 BeatCnt wraps only via clear in IDLE; Len = 2^BEATW-1 SHALL accept exactly 2^BEATW beats.
REQ-028 BusBusy SHALL be combinational from state only.

Reset
REQ-029 HRESETn low SHALL immediately force state IDLE, LSUSel 0, Len 0, BeatCnt 0, StarveCnt 0; outputs then grants 0, HTRANS 00, BusBusy 0, stalls = requests.
REQ-030 Reset asserted mid-tenure SHALL abandon the transfer with no further grant; first arbitration occurs in the first cycle after release.

Verification
REQ-031 Single LSU read, LSUBurstLen=0, HREADY=1 -> LSUGnt cycle 1, one beat, LASTDATA cycle 2, IDLE cycle 3, HTRANS=10 only in cycle 1.
REQ-032 IFU burst Len=3, HREADY low every other cycle -> exactly 4 accepted beats, BeatCnt 0..3, grant held through LASTDATA until HREADY.
REQ-033 Both requesting continuously, FAIRLIMIT=2 -> winner sequence LSU, LSU, IFU, LSU, LSU, IFU.
REQ-034 LSUReq rises during IFU tenure -> IFU not preempted, LSUStall=1, LSU granted after 1 IDLE cycle.
REQ-035 Owner drops request with HTRANS=00 in first ADDR cycle -> IDLE next cycle, BeatCnt=0, no beat counted.
REQ-036 HRESETn pulsed low mid-burst (BeatCnt=2) -> grants 0, HTRANS 00, BeatCnt 0 asynchronously; normal arbitration after release.

Source files
------------

// File: rtl/ebu_arb.sv
// External bus arbiter: grants the shared AHB port to the IFU or the LSU for
// one burst tenure, with a starvation limit that protects the IFU.
module ebu_arb #(
   parameter int BEATW     = 3,
   parameter int FAIRLIMIT = 2
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             IFUReq,
   input  logic             LSUReq,
   input  logic [BEATW-1:0] IFUBurstLen,
   input  logic [BEATW-1:0] LSUBurstLen,
   input  logic [1:0]       IFUHTRANS,
   input  logic [1:0]       LSUHTRANS,
   input  logic             HREADY,
   output logic             IFUGnt,
   output logic             LSUGnt,
   output logic             LSUSel,
   output logic [1:0]       HTRANS,
   output logic             IFUStall,
   output logic             LSUStall,
   output logic [BEATW-1:0] BeatCnt,
   output logic             BusBusy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_LAST
   } state_e;

   localparam logic [1:0] FAIR = FAIRLIMIT[1:0];

   state_e           state_q, state_d;
   logic             sel_q, sel_d;
   logic [BEATW-1:0] len_q, len_d;
   logic [BEATW-1:0] beat_q, beat_d;
   logic [1:0]       starve_q, starve_d;

   logic             win_lsu;
   logic             own_req;
   logic [1:0]       own_trans;
   logic             busy;
   logic             last_done;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q  <= ST_IDLE;
         sel_q    <= 1'b0;
         len_q    <= '0;
         beat_q   <= '0;
         starve_q <= 2'b00;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         len_q    <= len_d;
         beat_q   <= beat_d;
         starve_q <= starve_d;
      end
   end

   // IFU wins a contested cycle once the LSU has won FAIRLIMIT in a row
   assign win_lsu   = LSUReq & ~(IFUReq & (starve_q == FAIR));
   assign own_req   = sel_q ? LSUReq : IFUReq;
   assign own_trans = sel_q ? LSUHTRANS : IFUHTRANS;

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      len_d    = len_q;
      beat_d   = beat_q;
      starve_d = starve_q;
      unique case (state_q)
         ST_IDLE: begin
            if (IFUReq | LSUReq) begin
               state_d = ST_ADDR;
               sel_d   = win_lsu;
               len_d   = win_lsu ? LSUBurstLen : IFUBurstLen;
               beat_d  = '0;
               if (!win_lsu) begin
                  starve_d = 2'b00;
               end else if (IFUReq && starve_q != 2'b11) begin
                  starve_d = starve_q + 2'd1;
               end
            end
         end
         ST_ADDR: begin
            if (beat_q == '0 && !own_req && own_trans == 2'b00) begin
               state_d = ST_IDLE;
            end else if (HREADY && own_trans[1]) begin
               if (beat_q == len_q) begin
                  state_d = ST_LAST;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         ST_LAST: begin
            if (HREADY) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy      = (state_q != ST_IDLE);
   assign last_done = (state_q == ST_LAST) & HREADY;

   assign BusBusy  = busy;
   assign LSUSel   = sel_q;
   assign BeatCnt  = beat_q;
   assign IFUGnt   = busy & ~sel_q;
   assign LSUGnt   = busy & sel_q;
   assign HTRANS   = (state_q == ST_ADDR) ? own_trans : 2'b00;
   assign IFUStall = (IFUReq & ~IFUGnt) | (IFUGnt & ~last_done);
   assign LSUStall = (LSUReq & ~LSUGnt) | (LSUGnt & ~last_done);

endmodule
